// File: rtl/scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : scan_counter
// Description : Modulo-N up/down counter with clock prescaler, synchronous
//               clamped load, step/wrap strobes and registered one-hot decode.
//               Drives display digit multiplexing and operand selection.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_counter #(
  parameter int WIDTH    = 2,
  parameter int MODULO   = 4,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up_dn,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic [MODULO-1:0] sel,
  output logic              tick,
  output logic              tc
);

  // Prescaler is at least one bit wide; with PRESCALE=1 it never leaves 0.
  localparam int                c_PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]   c_MAX      = WIDTH'(MODULO - 1);
  localparam logic [MODULO-1:0]  c_SEL_ONE  = {{(MODULO-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   r_count;
  logic [MODULO-1:0]  r_sel;
  logic               r_tick;
  logic               r_tc;
  logic [c_PRE_W-1:0] r_pre;

  logic [WIDTH-1:0]   w_cnt_nxt;
  logic [MODULO-1:0]  w_sel_nxt;
  logic [c_PRE_W-1:0] w_pre_nxt;
  logic               w_step;
  logic               w_wrap;

  // Next-state: load beats stepping, stepping happens when the prescaler expires.
  always_comb begin
    w_cnt_nxt = r_count;
    w_pre_nxt = r_pre;
    w_step    = 1'b0;
    w_wrap    = 1'b0;
    if (load) begin
      w_pre_nxt = '0;
      w_cnt_nxt = (load_val > c_MAX) ? c_MAX : load_val;
    end else if (en) begin
      if (r_pre == c_PRE_LAST) begin
        w_pre_nxt = '0;
        w_step    = 1'b1;
      end else begin
        w_pre_nxt = r_pre + 1'b1;
      end
      if (w_step) begin
        if (up_dn) begin
          if (r_count == c_MAX) begin
            w_cnt_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_cnt_nxt = r_count + 1'b1;
          end
        end else begin
          if (r_count == '0) begin
            w_cnt_nxt = c_MAX;
            w_wrap    = 1'b1;
          end else begin
            w_cnt_nxt = r_count - 1'b1;
          end
        end
      end
    end
    // Decode from the next count so sel is registered in lockstep with count.
    w_sel_nxt = c_SEL_ONE << w_cnt_nxt;
  end

  // State register: count, decode, strobes and prescaler update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_sel   <= c_SEL_ONE;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
      r_pre   <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_tick  <= w_step;
      r_tc    <= w_wrap;
      r_pre   <= w_pre_nxt;
    end
  end

  assign count = r_count;
  assign sel   = r_sel;
  assign tick  = r_tick;
  assign tc    = r_tc;

endmodule
`default_nettype wire

// File: doc/scan_counter.md
# scan_counter

Parametrised modulo-N up/down counter with a clock prescaler, synchronous load, terminal-count strobe and registered one-hot decode. It replaces the free-running 2-bit counter that drives calculator display digit multiplexing. It sits between the system clock and the 7-segment digit-select / operand-mux logic. With default parameters, `en=1` and `up_dn=1`, it behaves as a free-running 2-bit wrap counter, plus reset.

## Interface
- `WIDTH`, default 2: count width in bits; must be ≥1.
- `MODULO`, default 4: count range 0..MODULO-1; legal range 2..2^WIDTH.
- `PRESCALE`, default 1: enabled clk cycles per count step; must be ≥1, and 1 means step on every enabled cycle.
- `clk`, input, 1: single clock, rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: count enable; gates the prescaler and stepping.
- `up_dn`, input, 1: direction; 1 = up, 0 = down.
- `load`, input, 1: synchronous load request.
- `load_val`, input, WIDTH: value loaded when `load`=1.
- `count`, output, WIDTH: current count (registered).
- `sel`, output, MODULO: one-hot decode of `count`; `sel[count]`=1 (registered).
- `tick`, output, 1: one-cycle strobe in the cycle a stepped value first appears on `count`.
- `tc`, output, 1: one-cycle strobe in the cycle a wrapped value first appears on `count`.

## Operation
- Reset (`rst_n`=0, asynchronous): `count`=0, `sel`=1 (bit 0 only), `tick`=0, `tc`=0, and the internal prescaler is 0. The block holds these values while `rst_n`=0; on release, the first active edge behaves normally.
- Internal prescaler `pre` is ceil(log2(PRESCALE)) bits wide, with a minimum of 1 bit. When PRESCALE=1, `pre` is constant 0.
- Priority on each rising edge: reset, then load, then step, then hold.
- Load (`load`=1, independent of `en`):
  - `count` takes `load_val`; if `load_val` ≥ MODULO, it takes MODULO-1 (clamp).
  - `pre` is cleared to 0.
  - `tick`=0 and `tc`=0 that cycle.
- Enabled, no load (`en`=1, `load`=0):
  - If `pre` == PRESCALE-1: `pre` goes to 0 and a step occurs.
  - Otherwise `pre` increments and `count` holds.
- Step up: if `count` == MODULO-1, `count` goes to 0 and `tc`=1; else `count`+1.
- Step down: if `count` == 0, `count` goes to MODULO-1 and `tc`=1; else `count`-1.
- `tick`=1 on every step; both strobes are 0 in all non-step cycles.
- Hold (`en`=0, `load`=0): `count` and `pre` frozen; `tick`=0, `tc`=0.
- `up_dn` is sampled only on the step edge. A direction change applies to the next step; `pre` is not disturbed.
- Arithmetic is modulo MODULO, not 2^WIDTH. When MODULO < 2^WIDTH, `count` never shows values ≥ MODULO.
- `sel` is registered alongside `count`, never decoded combinationally from the output. Exactly one bit of `sel` is set at all times.

## Timing
- All outputs change only on a rising `clk` edge or asynchronously on `rst_n` assertion.
- Step latency: with `en` held at 1 from a cleared `pre`, the first step appears PRESCALE edges later; steady state is one step per PRESCALE enabled cycles.
- `tick` and `tc` each last exactly one clk cycle.
  - They coincide with the new `count`/`sel` value, so back-to-back strobes occur only when PRESCALE=1.
  - With PRESCALE=1 and `en`=1, `tick` stays high continuously.
- Load latency: `load_val` (clamped) is visible on `count`/`sel` the cycle after the sampling edge.
- `en` deassertion mid-prescale: the partial count is retained and resumes when `en` returns.
- Reset asserted mid-operation: the block returns to the reset values immediately, with no strobe.

## Test plan
1. **Default free-run.** WIDTH=2, MODULO=4, PRESCALE=1, `en`=1, `up_dn`=1 from reset → `count` runs 0,1,2,3,0,1…, `sel` runs 0001,0010,0100,1000,0001…; `tick` is constantly 1 and `tc`=1 only in the cycles where `count`=0 after a wrap.
2. **Non-power-of-two down count with prescale.** WIDTH=3, MODULO=5, PRESCALE=3, `up_dn`=0 → `count` steps every 3 cycles: 0,4,3,2,1,0,4…; `tc`=1 with each 4 and each 0-after-1? No: `tc`=1 only on the 0→4 transition; `tick` is a single pulse every 3 cycles.
3. **Load and clamp.** Load 2, then load 7 with MODULO=5, including once while `en`=0 → `count`=2, then `count`=4; `sel`=00100, then 10000; `tick` and `tc` stay 0 on load cycles and `pre` restarts.
4. **Enable gating.** PRESCALE=4; drop `en` after 2 enabled cycles for 10 cycles, then raise it again → `count` frozen during the gap; the next step occurs exactly 2 enabled cycles after `en` returns.
5. **Direction change and simultaneous events.** Flip `up_dn` at `count`=MODULO-1 → the next step goes to MODULO-2 with no `tc`. Assert `load` on a step edge → load wins, with no `tick`.
6. **Asynchronous reset mid-count.** Pulse `rst_n` low between clk edges at `count`=3 → `count`=0, `sel`=0001, strobes 0 immediately, without waiting for a clk edge; normal counting resumes after release.
